// File: rtl/rf_write_ctrl.sv
// Write-side initiator for the register file: an in-order write queue fed by
// a valid/ready handshake, drained one entry per cycle onto the write port.
// Operands that still have a pending write in the queue get the queued value
// forwarded, so decode never reads stale register file data.
module rf_write_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rf_busy,
  output logic              sto,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] databus1,
  input  logic [DATA_W-1:0] databus2,
  output logic [DATA_W-1:0] op_data1,
  output logic [DATA_W-1:0] op_data2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [15:0]       wr_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  fwd_idx;

  logic not_empty;
  logic zero_dest;
  logic push;
  logic pop;

  assign not_empty = (count != '0);
  // No pass-through: a full queue refuses even if a pop happens this cycle.
  assign in_ready  = (count < CNT_W'(DEPTH));
  // Writes to the hardwired zero register complete the handshake but vanish.
  assign zero_dest = (ZERO_REG != 0) && (in_addr == '0);
  assign push      = in_valid && in_ready && !zero_dest;
  // sto is derived from count, so it drops together with the async reset.
  assign sto       = not_empty && !rf_busy;
  assign pop       = sto;
  assign waddr     = not_empty ? addr_q[head] : '0;
  assign dataIn    = not_empty ? data_q[head] : '0;

  // Queue storage; validity is tracked by count, so entries need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
  end

  // Head/tail pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of writes committed to the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (pop && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // Operand forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    op_data1 = databus1;
    op_data2 = databus2;
    fwd_hit1 = 1'b0;
    fwd_hit2 = 1'b0;
    fwd_idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (addr_q[fwd_idx] == rd_addr1) begin
          op_data1 = data_q[fwd_idx];
          fwd_hit1 = 1'b1;
        end
        if (addr_q[fwd_idx] == rd_addr2) begin
          op_data2 = data_q[fwd_idx];
          fwd_hit2 = 1'b1;
        end
      end
    end
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
      op_data1 = '0;
      fwd_hit1 = 1'b0;
    end
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
      op_data2 = '0;
      fwd_hit2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Bench for rf_write_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_rf_write_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_addr;
  logic [31:0] in_data;
  logic        rf_busy;
  logic        sto;
  logic [2:0]  waddr;
  logic [31:0] dataIn;
  logic [2:0]  rd_addr1;
  logic [2:0]  rd_addr2;
  logic [31:0] databus1;
  logic [31:0] databus2;
  logic [31:0] op_data1;
  logic [31:0] op_data2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [15:0] wr_count;

  rf_write_ctrl #(.DATA_W(32), .ADDR_W(3), .DEPTH(2), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .rf_busy  (rf_busy),
    .sto      (sto),
    .waddr    (waddr),
    .dataIn   (dataIn),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .databus1 (databus1),
    .databus2 (databus2),
    .op_data1 (op_data1),
    .op_data2 (op_data2),
    .fwd_hit1 (fwd_hit1),
    .fwd_hit2 (fwd_hit2),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_wc;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_fwd(input logic [2:0] ra, input logic [31:0] db,
                                  output logic [31:0] od, output logic hit);
    od  = db;
    hit = 1'b0;
    if (ra == 3'd0) begin
      od = 32'd0;
      return;
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == ra) begin
        od  = q[i].d;
        hit = 1'b1;
        break;
      end
    end
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, update model at posedge.
  task automatic step(input logic v, input logic [2:0] a, input logic [31:0] d,
                      input logic busy, input logic [2:0] r1, input logic [2:0] r2);
    logic        e_ready;
    logic        e_sto;
    logic [31:0] e_od1;
    logic [31:0] e_od2;
    logic        e_h1;
    logic        e_h2;
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    rf_busy  = busy;
    rd_addr1 = r1;
    rd_addr2 = r2;
    databus1 = $urandom;
    databus2 = $urandom;
    @(negedge clk);
    e_ready = (q.size() < 2);
    e_sto   = (q.size() > 0) && !busy;
    ref_fwd(r1, databus1, e_od1, e_h1);
    ref_fwd(r2, databus2, e_od2, e_h2);
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
    chk("sto",      {31'd0, sto},      {31'd0, e_sto});
    chk("waddr",    {29'd0, waddr},    (q.size() > 0) ? {29'd0, q[0].a} : 32'd0);
    chk("dataIn",   dataIn,            (q.size() > 0) ? q[0].d : 32'd0);
    chk("op_data1", op_data1,          e_od1);
    chk("op_data2", op_data2,          e_od2);
    chk("fwd_hit1", {31'd0, fwd_hit1}, {31'd0, e_h1});
    chk("fwd_hit2", {31'd0, fwd_hit2}, {31'd0, e_h2});
    chk("wr_count", {16'd0, wr_count}, {16'd0, m_wc});
    @(posedge clk);
    if (e_sto) begin
      void'(q.pop_front());
      if (m_wc != 16'hFFFF) m_wc++;
    end
    if (v && e_ready && (a != 3'd0)) q.push_back('{a: a, d: d});
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sto"},      {31'd0, sto},      32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_waddr"},    {29'd0, waddr},    32'd0);
    chk({tag, "_dataIn"},   dataIn,            32'd0);
    chk({tag, "_wr_count"}, {16'd0, wr_count}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    m_wc     = 16'd0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_addr  = 3'd0;
    in_data  = 32'd0;
    rf_busy  = 1'b0;
    rd_addr1 = 3'd0;
    rd_addr2 = 3'd0;
    databus1 = 32'd0;
    databus2 = 32'd0;
    #12;
    check_reset_state("por");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single write: visible on the write port the cycle after acceptance.
    step(1'b1, 3'd3, 32'hABCD1234, 1'b0, 3'd0, 3'd0);
    step(1'b0, 3'd0, 32'd0,        1'b0, 3'd3, 3'd1);
    step(1'b0, 3'd0, 32'd0,        1'b0, 3'd3, 3'd3);

    // Backpressure: queue fills while the port is busy, then drains in order.
    step(1'b1, 3'd1, 32'h11, 1'b1, 3'd1, 3'd2);
    step(1'b1, 3'd2, 32'h22, 1'b1, 3'd1, 3'd2);
    step(1'b1, 3'd7, 32'h77, 1'b1, 3'd1, 3'd2);
    step(1'b0, 3'd0, 32'd0,  1'b0, 3'd1, 3'd2);
    step(1'b0, 3'd0, 32'd0,  1'b0, 3'd1, 3'd2);
    step(1'b0, 3'd0, 32'd0,  1'b0, 3'd1, 3'd2);

    // Two pending writes to r5: the younger value must be forwarded.
    step(1'b1, 3'd5, 32'hAAAA0000, 1'b1, 3'd4, 3'd5);
    step(1'b1, 3'd5, 32'hBBBB0000, 1'b1, 3'd4, 3'd5);
    step(1'b0, 3'd0, 32'd0,        1'b1, 3'd5, 3'd5);
    step(1'b0, 3'd0, 32'd0,        1'b0, 3'd5, 3'd5);
    step(1'b0, 3'd0, 32'd0,        1'b0, 3'd5, 3'd5);
    step(1'b0, 3'd0, 32'd0,        1'b0, 3'd5, 3'd5);

    // Zero register: write discarded, reads return 0.
    step(1'b1, 3'd0, 32'hDEADBEEF, 1'b0, 3'd0, 3'd0);
    step(1'b0, 3'd0, 32'd0,        1'b0, 3'd0, 3'd0);
    step(1'b0, 3'd0, 32'd0,        1'b0, 3'd0, 3'd7);

    // Back-to-back stream: push and pop together, pointers wrap several times.
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 3'(i), $urandom, 1'b0, 3'(i), 3'(i - 1));
    end
    step(1'b0, 3'd0, 32'd0, 1'b0, 3'd6, 3'd5);
    step(1'b0, 3'd0, 32'd0, 1'b0, 3'd6, 3'd5);

    // Asynchronous reset mid-drain, asserted and released between edges.
    step(1'b1, 3'd4, 32'h44444444, 1'b1, 3'd4, 3'd6);
    step(1'b1, 3'd6, 32'h66666666, 1'b1, 3'd4, 3'd6);
    in_valid = 1'b0;
    rf_busy  = 1'b0;
    #1;
    chk("pre_rst_sto", {31'd0, sto}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_state("mid");
    q.delete();
    m_wc = 16'd0;
    #1;
    rst = 1'b1;
    step(1'b0, 3'd0, 32'd0, 1'b0, 3'd4, 3'd6);
    step(1'b0, 3'd0, 32'd0, 1'b0, 3'd4, 3'd6);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_ctrl.md
Name: rf_write_ctrl

Overview:
Write-side initiator for the 8x32 register file. Accepts writeback requests from the pipeline through a valid/ready handshake and buffers them in a small in-order queue. Drains one entry per cycle onto the register file write port (sto/waddr/dataIn). Bypasses pending, not-yet-committed values onto the two decode read operands, so decode never sees stale register file data.

Parameters:
DATA_W, 32, data width of register file words
ADDR_W, 3, register address width (8 registers)
DEPTH, 2, write queue entries; power of two, >=2
ZERO_REG, 1, when 1, register 0 is hardwired zero: writes to it are discarded and reads of it return 0

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  writeback request valid
in_ready  output  1  queue can accept a request
in_addr  input  ADDR_W  destination register
in_data  input  DATA_W  writeback value
rf_busy  input  1  register file write port unavailable this cycle
sto  output  1  register file write strobe
waddr  output  ADDR_W  register file write address
dataIn  output  DATA_W  register file write data
rd_addr1  input  ADDR_W  decode operand 1 address; also drives register file raddr1
rd_addr2  input  ADDR_W  decode operand 2 address; also drives register file raddr2
databus1  input  DATA_W  register file read data, port 1
databus2  input  DATA_W  register file read data, port 2
op_data1  output  DATA_W  resolved operand 1
op_data2  output  DATA_W  resolved operand 2
fwd_hit1  output  1  op_data1 taken from the queue
fwd_hit2  output  1  op_data2 taken from the queue
wr_count  output  16  committed-write counter

Behaviour:
- Reset (rst=0, asynchronous): queue emptied, all head/tail pointers and count cleared, wr_count=0. While the queue is empty: sto=0, waddr=0, dataIn=0, in_ready=1. Pending writes are lost if reset arrives mid-operation. sto must fall in the same instant as rst, not at the next clock edge.
- Push: on a rising edge with in_valid && in_ready, the request is appended at the tail.
  - in_ready = (count < DEPTH). There is no pass-through when the queue is full.
  - With ZERO_REG=1 and in_addr==0, the handshake completes but nothing is enqueued.
- Drain: sto = (count>0) && !rf_busy. waddr/dataIn = head entry whenever count>0, held stable while rf_busy=1. On a rising edge with sto=1, the head is popped and wr_count increments; wr_count saturates at 16'hFFFF.
- Simultaneous push and pop: count unchanged; pointers advance and wrap modulo DEPTH.
- Latency: a request accepted at edge N drives sto=1 during cycle N+1 at the earliest, and is written to the register file at edge N+1.
- Forwarding (combinational): for each port k, compare rd_addrk against every valid queue entry, head included, since the head's write has not yet landed.
  - On a match, op_datak = youngest matching entry's data and fwd_hitk=1.
  - Otherwise op_datak = databusk and fwd_hitk=0.
  - A request on in_* in the same cycle is not forwarded.
  - With ZERO_REG=1 and rd_addrk==0: op_datak=0, fwd_hitk=0.
- Writes commit to the register file in acceptance order. Two queued writes to the same register commit oldest first.

Test Plan:
- Reset then single write: in addr=3, data=32'hABCD1234 accepted at edge 1 -> sto=1, waddr=3, dataIn=ABCD1234 in cycle 2; wr_count=1 after edge 2; a later rd_addr1=3 shows databus1 value with fwd_hit1=0.
- Backpressure: rf_busy=1, push addr1=32'h11, addr2=32'h22 -> in_ready=0 after 2 pushes, head held at addr1=32'h11 with sto=0. Release rf_busy -> commits 11 then 22 on consecutive edges, in_ready=1 after the first pop.
- Forward youngest: queue holds r5=32'hAAAA0000 then r5=32'hBBBB0000, rd_addr2=5 -> op_data2=32'hBBBB0000, fwd_hit2=1. After both drain -> fwd_hit2=0.
- Zero register: push addr0=32'hDEADBEEF -> no sto ever asserted, wr_count unchanged; rd_addr1=0 -> op_data1=0.
- Simultaneous push/pop, full wrap: stream 6 back-to-back writes r1..r6 with rf_busy=0 -> one commit per edge in order, count never exceeds 1, wr_count=6.
- Async reset mid-drain: 2 entries queued, pull rst low between edges -> sto=0 immediately, in_ready=1, wr_count=0. After release, no stale commit occurs.
